// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key controller slice.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } ps2_state_e;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Scan-code FIFO handshake between ps2_keyboard (master) and its consumer (slave).
interface ps2_key_ctrl_if;
  import ps2_pkg::*;

  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  modport master (
    output ready,
    output data,
    output overflow,
    input  nextdata_n
  );

  modport slave (
    input  ready,
    input  data,
    input  overflow,
    output nextdata_n
  );

endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational PS/2 set-2 scan code to lowercase ASCII lookup; unmapped codes give 0.
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  // Lookup of letters, digits, space and enter.
  always_comb begin
    ascii = 8'h00;
    unique case (code)
      8'h1C: ascii = 8'h61; // a
      8'h32: ascii = 8'h62; // b
      8'h21: ascii = 8'h63; // c
      8'h23: ascii = 8'h64; // d
      8'h24: ascii = 8'h65; // e
      8'h2B: ascii = 8'h66; // f
      8'h34: ascii = 8'h67; // g
      8'h33: ascii = 8'h68; // h
      8'h43: ascii = 8'h69; // i
      8'h3B: ascii = 8'h6A; // j
      8'h42: ascii = 8'h6B; // k
      8'h4B: ascii = 8'h6C; // l
      8'h3A: ascii = 8'h6D; // m
      8'h31: ascii = 8'h6E; // n
      8'h44: ascii = 8'h6F; // o
      8'h4D: ascii = 8'h70; // p
      8'h15: ascii = 8'h71; // q
      8'h2D: ascii = 8'h72; // r
      8'h1B: ascii = 8'h73; // s
      8'h2C: ascii = 8'h74; // t
      8'h3C: ascii = 8'h75; // u
      8'h2A: ascii = 8'h76; // v
      8'h1D: ascii = 8'h77; // w
      8'h22: ascii = 8'h78; // x
      8'h35: ascii = 8'h79; // y
      8'h1A: ascii = 8'h7A; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      8'h5A: ascii = 8'h0D; // enter
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Pops the PS/2 scan-code FIFO, decodes make/break/extended sequences,
// tracks the last held key and counts completed press+release strokes.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_ctrl_if.slave    fifo,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             make_pulse,
  output logic             break_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic [7:0]       ascii,
  output logic             ovf_sticky
);

  ps2_state_e       state, state_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic             nextdata_n_q, nextdata_n_nxt;
  logic             ext_pend, ext_pend_nxt;
  logic             brk_pend, brk_pend_nxt;
  logic [7:0]       key_code_nxt;
  logic             key_ext_nxt;
  logic             key_down_nxt;
  logic             make_nxt;
  logic             break_nxt;
  logic [CNT_W-1:0] press_cnt_nxt;
  logic             same_key;
  logic [7:0]       rom_ascii;

  assign fifo.nextdata_n = nextdata_n_q;

  // The byte being decoded refers to the tracked key in the same E0 space.
  assign same_key = key_down && (byte_q == key_code) && (ext_pend == key_ext);

  // Next-state and next-output logic; pulses default low so they last one cycle.
  always_comb begin
    state_nxt      = state;
    byte_nxt       = byte_q;
    nextdata_n_nxt = nextdata_n_q;
    ext_pend_nxt   = ext_pend;
    brk_pend_nxt   = brk_pend;
    key_code_nxt   = key_code;
    key_ext_nxt    = key_ext;
    key_down_nxt   = key_down;
    make_nxt       = 1'b0;
    break_nxt      = 1'b0;
    press_cnt_nxt  = press_cnt;
    unique case (state)
      IDLE: begin
        if (fifo.ready) begin
          byte_nxt       = fifo.data;
          nextdata_n_nxt = 1'b0;
          state_nxt      = POP;
        end
      end
      POP: begin
        nextdata_n_nxt = 1'b1;
        state_nxt      = SETTLE;
        if (byte_q == PS2_EXT) begin
          ext_pend_nxt = 1'b1;
        end else if (byte_q == PS2_BREAK) begin
          brk_pend_nxt = 1'b1;
        end else if (brk_pend) begin
          // Releases of anything but the tracked key are dropped silently.
          if (same_key) begin
            key_down_nxt  = 1'b0;
            break_nxt     = 1'b1;
            press_cnt_nxt = press_cnt + CNT_W'(1);
          end
          brk_pend_nxt = 1'b0;
          ext_pend_nxt = 1'b0;
        end else begin
          // A make of the already-held key is typematic repeat and is ignored.
          if (!same_key) begin
            key_code_nxt = byte_q;
            key_ext_nxt  = ext_pend;
            key_down_nxt = 1'b1;
            make_nxt     = 1'b1;
          end
          ext_pend_nxt = 1'b0;
        end
      end
      SETTLE: begin
        // Dead cycle so the FIFO head reflects the pop before it is sampled.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset also drops any pending E0/F0 prefix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      nextdata_n_q <= 1'b1;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      key_code     <= 8'h00;
      key_ext      <= 1'b0;
      key_down     <= 1'b0;
      make_pulse   <= 1'b0;
      break_pulse  <= 1'b0;
      press_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      nextdata_n_q <= nextdata_n_nxt;
      ext_pend     <= ext_pend_nxt;
      brk_pend     <= brk_pend_nxt;
      key_code     <= key_code_nxt;
      key_ext      <= key_ext_nxt;
      key_down     <= key_down_nxt;
      make_pulse   <= make_nxt;
      break_pulse  <= break_nxt;
      press_cnt    <= press_cnt_nxt;
    end
  end

  // Captured FIFO byte; only meaningful in POP, so it needs no reset.
  always_ff @(posedge clk) begin
    byte_q <= byte_nxt;
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (fifo.overflow) begin
      ovf_sticky <= 1'b1;
    end
  end

  ps2_scan2ascii u_scan2ascii (
    .code  (key_code),
    .ascii (rom_ascii)
  );

  // Extended keys have no ASCII meaning on this path.
  assign ascii = key_ext ? 8'h00 : rom_ascii;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized and directed bench for ps2_key_ctrl with a FIFO model and a
// key-event reference model.
module tb_ps2_key_ctrl;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic       make_pulse;
  logic       break_pulse;
  logic [7:0] press_cnt;
  logic [7:0] ascii;
  logic       ovf_sticky;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo        (bus.slave),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_down    (key_down),
    .make_pulse  (make_pulse),
    .break_pulse (break_pulse),
    .press_cnt   (press_cnt),
    .ascii       (ascii),
    .ovf_sticky  (ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ASCII reference tables written from the set-2 key layout.
  logic [7:0] az_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dg_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] exp_ascii(input logic [7:0] code, input logic ext);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++) if (az_codes[i] == code) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (dg_codes[i] == code) return 8'h30 + 8'(i);
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  // FIFO contents and reference-model state.
  logic [7:0] fq [$];
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0, m_down = 1'b0, m_ext_p = 1'b0, m_brk_p = 1'b0;
  int         m_cnt = 0, m_makes = 0, m_breaks = 0, m_pops = 0;
  int         o_makes = 0, o_breaks = 0, o_lows = 0;
  int         cyc = 0, last_low = -1000;
  logic       pend_pop = 1'b0;
  logic [7:0] popped;

  // Interpret one consumed byte as a keyboard event stream.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext_p = 1'b1;
    else if (b == 8'hF0) m_brk_p = 1'b1;
    else if (m_brk_p) begin
      if (m_down && b == m_code && m_ext_p == m_ext) begin
        m_down = 1'b0;
        m_breaks++;
        m_cnt = (m_cnt + 1) % 256;
      end
      m_brk_p = 1'b0;
      m_ext_p = 1'b0;
    end else begin
      if (!(m_down && b == m_code && m_ext_p == m_ext)) begin
        m_code = b;
        m_ext  = m_ext_p;
        m_down = 1'b1;
        m_makes++;
      end
      m_ext_p = 1'b0;
    end
  endtask

  // FIFO model plus monitor: pops after a low nextdata_n seen with ready, counts pulses.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0;
      m_ext_p = 1'b0; m_brk_p = 1'b0; m_cnt = 0;
    end
    if (pend_pop && fq.size() != 0) begin
      popped = fq.pop_front();
      m_pops++;
      model_byte(popped);
    end
    pend_pop = !bus.nextdata_n && bus.ready;
    if (!bus.nextdata_n) begin
      o_lows++;
      chk("pop_gap", 32'(cyc - last_low >= 3), 32'd1);
      last_low = cyc;
    end
    if (make_pulse) o_makes++;
    if (break_pulse) o_breaks++;
    if (make_pulse || break_pulse) chk("pulse_excl", 32'(make_pulse & break_pulse), 32'd0);
    bus.ready = (fq.size() != 0);
    bus.data  = (fq.size() != 0) ? fq[0] : 8'h00;
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((fq.size() != 0 || pend_pop) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_drain"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_code"},   32'(key_code),  32'(m_code));
    chk({tag, "_ext"},    32'(key_ext),   32'(m_ext));
    chk({tag, "_down"},   32'(key_down),  32'(m_down));
    chk({tag, "_cnt"},    32'(press_cnt), 32'(m_cnt));
    chk({tag, "_ascii"},  32'(ascii),     32'(exp_ascii(m_code, m_ext)));
    chk({tag, "_makes"},  32'(o_makes),   32'(m_makes));
    chk({tag, "_breaks"}, 32'(o_breaks),  32'(m_breaks));
    chk({tag, "_lows"},   32'(o_lows),    32'(m_pops));
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] pool [6] = '{8'h1C, 8'h45, 8'h29, 8'h75, 8'h76, 8'h5A};
  logic [7:0] k;

  initial begin
    bus.overflow = 1'b0;
    do_reset();
    chk("rst_ndn",  32'(bus.nextdata_n), 32'd1);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_down", 32'(key_down), 32'd0);
    chk("rst_cnt",  32'(press_cnt), 32'd0);
    chk("rst_ovf",  32'(ovf_sticky), 32'd0);
    chk("rst_mk",   32'(make_pulse | break_pulse), 32'd0);

    push(8'h1C); drain("t1"); check_state("t1");
    chk("t1_ascii_a", 32'(ascii), 32'h61);

    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain("t2"); check_state("t2");
    chk("t2_cnt1", 32'(press_cnt), 32'd1);

    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain("t3"); check_state("t3");

    do_reset();
    push(8'hE0); push(8'h75);
    drain("t3b"); check_state("t3b");
    chk("t3b_ascii0", 32'(ascii), 32'd0);

    do_reset();
    push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h32);
    drain("t4"); check_state("t4");
    chk("t4_cnt1", 32'(press_cnt), 32'd1);

    push(8'h1C); push(8'hE0); push(8'hF0);
    drain("t5a");
    do_reset();
    chk("t5_rst_cnt", 32'(press_cnt), 32'd0);
    push(8'h1C); drain("t5"); check_state("t5");

    for (int i = 0; i < 60; i++) begin
      k = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) push(8'hE0);
      if ($urandom_range(0, 2) == 0) push(8'hF0);
      push(k);
      if ($urandom_range(0, 4) == 0) push(k);
      drain("rnd"); check_state("rnd");
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      push(8'h45);
      drain("wrap");
      if (i == 0) chk("wrap_ascii", 32'(ascii), 32'h30);
      push(8'hF0); push(8'h45);
      drain("wrap");
    end
    check_state("wrap");
    chk("wrap_cnt0", 32'(press_cnt), 32'd0);

    chk("ovf_pre", 32'(ovf_sticky), 32'd0);
    bus.overflow = 1'b1;
    @(negedge clk);
    bus.overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(ovf_sticky), 32'd1);
    push(8'h1C); drain("ovf");
    chk("ovf_hold", 32'(ovf_sticky), 32'd1);
    check_state("ovf");
    do_reset();
    chk("ovf_clr", 32'(ovf_sticky), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
